rtsnoc_port_arbiter: RTL and testbench
======================================

RTSNOC_PORT_ARBITER -- requirements
Module: rtsnoc_port_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): SOC_SIZE_X, 1, log2 mesh width; SOC_SIZE_Y, 1, log2 mesh height; NOC_DATA_WIDTH, 16, flit payload bits.
REQ-002 SHALL derive BUS = NOC_DATA_WIDTH + 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6.
REQ-003 SHALL treat the flit as {orig_x, orig_y, orig_local[2:0], dst_x, dst_y, dst_local[2:0], data}, MSB first.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk_i, in, 1, the single clock.
- rst_i, in, 1, synchronous, active-high reset.
- req_i, in, 4, per-client transmit request.
- flit_i, in, 4*BUS, client k flit at bits [k*BUS +: BUS].
- ack_o, out, 4, one-cycle pulse: client k flit written to the router.
- din_o, out, BUS, flit to the router local port.
- wr_o, out, 1, router write strobe.
- wait_i, in, 1, router busy; a write is blocked while high.
- dout_i, in, BUS, router output flit, valid while nd_i is high.
- nd_i, in, 1, router holds new data.
- rd_o, out, 1, one-cycle router pop strobe.
- rx_data_o, out, BUS, delivered flit.
- rx_valid_o, out, 4, per-client delivery valid.
- rx_ready_i, in, 4, per-client delivery accept.
- drop_o, out, 1, one-cycle pulse: undeliverable flit discarded.

Function
REQ-005 SHALL run a TX FSM with states T_IDLE and T_SEND.
REQ-006 T_IDLE: if any req_i is set, SHALL register the grant index g and flit_i[g] into din_o, then enter T_SEND. Grant is round-robin, searching from last_grant+1 modulo 4.
REQ-007 T_SEND: SHALL drive wr_o = !wait_i combinationally. In a cycle with wr_o=1, SHALL pulse ack_o[g], set last_grant=g, and return to T_IDLE.
REQ-008 While wait_i=1, SHALL hold din_o and g stable indefinitely. Requester deassertion in T_SEND SHALL NOT cancel the write.
REQ-009 Minimum TX latency: req_i at cycle n -> wr_o and ack_o at cycle n+1. Maximum throughput is one flit per 2 cycles.
REQ-010 Clients SHALL hold req_i and flit_i until ack_o. ack_o SHALL be one-hot or zero.
REQ-011 SHALL run an RX FSM with states R_IDLE and R_HOLD.
REQ-012 R_IDLE with nd_i=1: SHALL pulse rd_o, capture dout_i into rx_data_o, and act on dst_local:
- dst_local[2]=0: enter R_HOLD.
- dst_local[2]=1: pulse drop_o the following cycle and remain in R_IDLE.
REQ-013 R_HOLD: SHALL assert rx_valid_o[dst_local[1:0]] only. On the matching rx_ready_i, SHALL deassert it and return to R_IDLE.
REQ-014 After rd_o, SHALL NOT issue another rd_o for at least 2 cycles.
REQ-015 TX and RX SHALL operate independently. Simultaneous nd_i and req_i SHALL both be serviced without stalling each other.
REQ-016 rx_data_o SHALL be stable for the whole of R_HOLD.

Reset
REQ-017 When rst_i=1 at a clock edge, SHALL set:
- both FSMs to IDLE;
- last_grant=3, so client 0 has first priority;
- din_o=0 and rx_data_o=0;
- wr_o, rd_o, ack_o, rx_valid_o and drop_o all 0.
REQ-018 Reset mid-operation SHALL discard any pending TX grant or held RX flit, with no ack_o and no rx_valid_o.

Configuration
REQ-019 With RTSNOC_ARB_FIXED_PRIO_EN defined, T_IDLE SHALL grant the lowest-index requesting client, and last_grant SHALL be unused.
REQ-020 Without RTSNOC_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-006.

Verification
REQ-021 req_i=4'b1111 held, wait_i=0 -> ack_o sequence 0001, 0010, 0100, 1000, 0001, one ack every 2 cycles. With RTSNOC_ARB_FIXED_PRIO_EN: 0001 repeated.
REQ-022 req_i=4'b0100, wait_i=1 for 5 cycles -> din_o = flit_i[2] held, wr_o=0. Release wait_i -> wr_o=1 and ack_o=0100 in the same cycle.
REQ-023 nd_i=1 with dst_local=3'b010 and data 16'hBEEF -> rd_o pulse, then rx_valid_o=0100 and rx_data_o data 16'hBEEF. Holding rx_ready_i[2]=0 for 10 cycles -> no further rd_o.
REQ-024 nd_i=1 with dst_local=3'b101 -> rd_o pulse, drop_o pulse one cycle later, rx_valid_o stays 0.
REQ-025 Assert rst_i during T_SEND with wait_i=1 and during R_HOLD -> next cycle all outputs 0, no ack_o, and client 0 is granted first afterwards.
REQ-026 Concurrent req_i=0001 and nd_i=1 with dst_local=0 -> ack_o[0] and rx_valid_o[0] both occur within 2 cycles.

Source files
------------

// File: rtl/rtsnoc_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rtsnoc_port_arbiter                                             |
// | Purpose  : Shares one router local port among four clients (TX arbitration |
// |            with ack) and routes router output flits to one of four clients |
// |            or discards them (RX).                                          |
// | Options  : RTSNOC_ARB_FIXED_PRIO_EN - lowest-index client wins instead of  |
// |            round-robin arbitration.                                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rtsnoc_port_arbiter #(
    parameter int SOC_SIZE_X     = 1,
    parameter int SOC_SIZE_Y     = 1,
    parameter int NOC_DATA_WIDTH = 16,
    localparam int BUS = NOC_DATA_WIDTH + 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       req_i,
    input  logic [4*BUS-1:0] flit_i,
    output logic [3:0]       ack_o,
    output logic [BUS-1:0]   din_o,
    output logic             wr_o,
    input  logic             wait_i,
    input  logic [BUS-1:0]   dout_i,
    input  logic             nd_i,
    output logic             rd_o,
    output logic [BUS-1:0]   rx_data_o,
    output logic [3:0]       rx_valid_o,
    input  logic [3:0]       rx_ready_i,
    output logic             drop_o
);

    typedef enum logic [0:0] {
        T_IDLE = 1'b0,
        T_SEND = 1'b1
    } tx_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_HOLD = 1'b1
    } rx_state_t;

    localparam int         DST_LOCAL_LSB = NOC_DATA_WIDTH;
    localparam logic [1:0] RD_GAP        = 2'd2;

    // ------------------------------------------------------------------
    // TX side
    // ------------------------------------------------------------------
    tx_state_t        tx_state;
    logic [1:0]       grant;
    logic [1:0]       arb_idx;
    logic [BUS-1:0]   arb_flit;
    logic             tx_fire;

`ifndef RTSNOC_ARB_FIXED_PRIO_EN
    logic [1:0]       last_grant;
    logic [1:0]       arb_cand;
`endif

    assign tx_fire = !rst_i && (tx_state == T_SEND) && !wait_i;
    assign wr_o    = tx_fire;

    always_comb begin
        ack_o = 4'b0000;
        if (tx_fire) begin
            ack_o[grant] = 1'b1;
        end
    end

`ifdef RTSNOC_ARB_FIXED_PRIO_EN
    always_comb begin
        arb_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req_i[i]) begin
                arb_idx = 2'(i);
            end
        end
    end
`else
    // Scan from the lowest priority (last_grant) up to the highest
    // (last_grant+1) so the last hit is the round-robin winner.
    always_comb begin
        arb_idx  = 2'd0;
        arb_cand = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            arb_cand = last_grant + 2'(i);
            if (req_i[arb_cand]) begin
                arb_idx = arb_cand;
            end
        end
    end
`endif

    assign arb_flit = flit_i[int'(arb_idx)*BUS +: BUS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state   <= T_IDLE;
            grant      <= 2'd0;
            din_o      <= '0;
`ifndef RTSNOC_ARB_FIXED_PRIO_EN
            last_grant <= 2'd3;
`endif
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (|req_i) begin
                        grant    <= arb_idx;
                        din_o    <= arb_flit;
                        tx_state <= T_SEND;
                    end
                end
                T_SEND: begin
                    // grant and din_o stay frozen until the router accepts.
                    if (tx_fire) begin
                        tx_state   <= T_IDLE;
`ifndef RTSNOC_ARB_FIXED_PRIO_EN
                        last_grant <= grant;
`endif
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX side
    // ------------------------------------------------------------------
    rx_state_t        rx_state;
    logic [1:0]       rd_gap_cnt;
    logic             rd_fire;
    logic             dout_drop;
    logic [1:0]       rx_client;

    assign dout_drop = dout_i[DST_LOCAL_LSB + 2];
    assign rx_client = rx_data_o[DST_LOCAL_LSB +: 2];
    assign rd_fire   = !rst_i && (rx_state == R_IDLE) && nd_i && (rd_gap_cnt == 2'd0);
    assign rd_o      = rd_fire;

    always_comb begin
        rx_valid_o = 4'b0000;
        if (rx_state == R_HOLD) begin
            rx_valid_o[rx_client] = 1'b1;
        end
    end

    // The gap counter gives the router time to retire nd_i after a pop,
    // so a stale nd_i never causes a second read of the same flit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state   <= R_IDLE;
            rx_data_o  <= '0;
            rd_gap_cnt <= 2'd0;
            drop_o     <= 1'b0;
        end else begin
            drop_o <= 1'b0;
            if (rd_gap_cnt != 2'd0) begin
                rd_gap_cnt <= rd_gap_cnt - 2'd1;
            end
            case (rx_state)
                R_IDLE: begin
                    if (rd_fire) begin
                        rx_data_o  <= dout_i;
                        rd_gap_cnt <= RD_GAP;
                        if (dout_drop) begin
                            drop_o <= 1'b1;
                        end else begin
                            rx_state <= R_HOLD;
                        end
                    end
                end
                R_HOLD: begin
                    if (rx_ready_i[rx_client]) begin
                        rx_state <= R_IDLE;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rtsnoc_port_arbiter.sv
`default_nettype none
// Bench for rtsnoc_port_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbiter rules.
module tb_rtsnoc_port_arbiter;

    localparam int BUS = 26;

    logic             clk;
    logic             rst_i;
    logic [3:0]       req_i;
    logic [4*BUS-1:0] flit_i;
    logic [3:0]       ack_o;
    logic [BUS-1:0]   din_o;
    logic             wr_o;
    logic             wait_i;
    logic [BUS-1:0]   dout_i;
    logic             nd_i;
    logic             rd_o;
    logic [BUS-1:0]   rx_data_o;
    logic [3:0]       rx_valid_o;
    logic [3:0]       rx_ready_i;
    logic             drop_o;

    int checks = 0;
    int errors = 0;

    rtsnoc_port_arbiter dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .flit_i     (flit_i),
        .ack_o      (ack_o),
        .din_o      (din_o),
        .wr_o       (wr_o),
        .wait_i     (wait_i),
        .dout_i     (dout_i),
        .nd_i       (nd_i),
        .rd_o       (rd_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .drop_o     (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BUS-1:0] mk_flit(input logic [2:0] dl, input logic [15:0] data);
        logic [BUS-1:0] f;
        f = BUS'($urandom);
        f[18:16] = dl;
        f[15:0]  = data;
        return f;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; req_i = '0; flit_i = '0; wait_i = 1'b0;
        dout_i = '0; nd_i = 1'b0; rx_ready_i = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (ack_o !== 4'b0) begin errors++; $display("FAIL reset_ack got %b exp 0000", ack_o); end
        checks++; if (wr_o !== 1'b0) begin errors++; $display("FAIL reset_wr got %b exp 0", wr_o); end
        checks++; if (rd_o !== 1'b0) begin errors++; $display("FAIL reset_rd got %b exp 0", rd_o); end
        checks++; if (rx_valid_o !== 4'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0000", rx_valid_o); end
        checks++; if (drop_o !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", drop_o); end
        checks++; if (din_o !== '0) begin errors++; $display("FAIL reset_din got %h exp 0", din_o); end
        checks++; if (rx_data_o !== '0) begin errors++; $display("FAIL reset_rx_data got %h exp 0", rx_data_o); end
        next_cycle();
    endtask

    // All four clients requesting: acks rotate 0,1,2,3,0 on every other cycle.
    task automatic test_round_robin();
        logic [BUS-1:0] fl [4];
        logic [3:0]     exp_ack;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            fl[k] = BUS'($urandom);
            flit_i[k*BUS +: BUS] = fl[k];
        end
        req_i = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            exp_ack = (i % 2 == 1) ? (4'b0001 << (((i - 1) / 2) % 4)) : 4'b0000;
            @(negedge clk);
            checks++;
            if (ack_o !== exp_ack) begin errors++; $display("FAIL rr_ack cycle %0d got %b exp %b", i, ack_o, exp_ack); end
            if (i % 2 == 1) begin
                checks++;
                if (din_o !== fl[((i - 1) / 2) % 4]) begin
                    errors++; $display("FAIL rr_din cycle %0d got %h exp %h", i, din_o, fl[((i - 1) / 2) % 4]);
                end
            end
            next_cycle();
        end
        req_i = 4'b0000;
        next_cycle();
    endtask

    // Router busy for 5 cycles; flit and grant must hold, even if the request drops.
    task automatic test_wait_hold();
        logic [BUS-1:0] f2;
        f2 = BUS'($urandom);
        flit_i = '0;
        flit_i[2*BUS +: BUS] = f2;
        req_i  = 4'b0100;
        wait_i = 1'b1;
        next_cycle();
        for (int i = 1; i <= 5; i++) begin
            if (i >= 3) begin
                req_i = 4'b0000;
                flit_i[2*BUS +: BUS] = ~f2;
            end
            @(negedge clk);
            checks++; if (wr_o !== 1'b0) begin errors++; $display("FAIL wait_wr cycle %0d got %b exp 0", i, wr_o); end
            checks++; if (ack_o !== 4'b0) begin errors++; $display("FAIL wait_ack cycle %0d got %b exp 0000", i, ack_o); end
            checks++; if (din_o !== f2) begin errors++; $display("FAIL wait_din cycle %0d got %h exp %h", i, din_o, f2); end
            next_cycle();
        end
        wait_i = 1'b0;
        @(negedge clk);
        checks++; if (wr_o !== 1'b1) begin errors++; $display("FAIL release_wr got %b exp 1", wr_o); end
        checks++; if (ack_o !== 4'b0100) begin errors++; $display("FAIL release_ack got %b exp 0100", ack_o); end
        next_cycle();
        req_i = 4'b0000;
        next_cycle();
    endtask

    task automatic test_rx_deliver();
        do_reset();
        dout_i = mk_flit(3'b010, 16'hBEEF);
        nd_i   = 1'b1;
        @(negedge clk);
        checks++; if (rd_o !== 1'b1) begin errors++; $display("FAIL deliver_rd got %b exp 1", rd_o); end
        next_cycle();
        dout_i = mk_flit(3'b001, 16'h1234);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (rd_o !== 1'b0) begin errors++; $display("FAIL hold_rd cycle %0d got %b exp 0", i, rd_o); end
            checks++; if (rx_valid_o !== 4'b0100) begin errors++; $display("FAIL hold_valid cycle %0d got %b exp 0100", i, rx_valid_o); end
            checks++; if (rx_data_o[15:0] !== 16'hBEEF) begin errors++; $display("FAIL hold_data cycle %0d got %h exp beef", i, rx_data_o[15:0]); end
            next_cycle();
        end
        rx_ready_i = 4'b0100;
        nd_i = 1'b0;
        next_cycle();
        rx_ready_i = 4'b0000;
        @(negedge clk);
        checks++; if (rx_valid_o !== 4'b0) begin errors++; $display("FAIL deliver_done_valid got %b exp 0000", rx_valid_o); end
        next_cycle();
    endtask

    task automatic test_rx_drop();
        do_reset();
        dout_i = mk_flit(3'b101, 16'h5A5A);
        nd_i   = 1'b1;
        @(negedge clk);
        checks++; if (rd_o !== 1'b1) begin errors++; $display("FAIL drop_rd got %b exp 1", rd_o); end
        checks++; if (drop_o !== 1'b0) begin errors++; $display("FAIL drop_early got %b exp 0", drop_o); end
        next_cycle();
        nd_i = 1'b0;
        @(negedge clk);
        checks++; if (drop_o !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b exp 1", drop_o); end
        checks++; if (rx_valid_o !== 4'b0) begin errors++; $display("FAIL drop_valid got %b exp 0000", rx_valid_o); end
        next_cycle();
        @(negedge clk);
        checks++; if (drop_o !== 1'b0) begin errors++; $display("FAIL drop_width got %b exp 0", drop_o); end
        checks++; if (rx_valid_o !== 4'b0) begin errors++; $display("FAIL drop_valid2 got %b exp 0000", rx_valid_o); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        // Move the round-robin pointer off its reset value first.
        req_i = 4'b0001;
        flit_i = {4{BUS'($urandom)}};
        next_cycle();
        next_cycle();
        req_i  = 4'b0010;
        wait_i = 1'b1;
        dout_i = mk_flit(3'b001, 16'hC0DE);
        nd_i   = 1'b1;
        next_cycle();
        nd_i = 1'b0;
        @(negedge clk);
        checks++; if (rx_valid_o !== 4'b0010) begin errors++; $display("FAIL mid_pre_valid got %b exp 0010", rx_valid_o); end
        checks++; if (wr_o !== 1'b0) begin errors++; $display("FAIL mid_pre_wr got %b exp 0", wr_o); end
        next_cycle();
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        req_i = 4'b1111;
        rx_ready_i = 4'b1111;
        @(negedge clk);
        checks++; if (ack_o !== 4'b0) begin errors++; $display("FAIL mid_ack got %b exp 0000", ack_o); end
        checks++; if (wr_o !== 1'b0) begin errors++; $display("FAIL mid_wr got %b exp 0", wr_o); end
        checks++; if (rx_valid_o !== 4'b0) begin errors++; $display("FAIL mid_valid got %b exp 0000", rx_valid_o); end
        checks++; if (din_o !== '0) begin errors++; $display("FAIL mid_din got %h exp 0", din_o); end
        checks++; if (rx_data_o !== '0) begin errors++; $display("FAIL mid_rx_data got %h exp 0", rx_data_o); end
        checks++; if (drop_o !== 1'b0 || rd_o !== 1'b0) begin errors++; $display("FAIL mid_drop_rd got %b%b exp 00", drop_o, rd_o); end
        next_cycle();
        wait_i = 1'b0;
        @(negedge clk);
        checks++; if (ack_o !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b exp 0001", ack_o); end
        next_cycle();
        req_i = 4'b0000;
        rx_ready_i = 4'b0000;
        next_cycle();
    endtask

    task automatic test_concurrent();
        do_reset();
        flit_i = '0;
        flit_i[0 +: BUS] = BUS'($urandom);
        req_i  = 4'b0001;
        dout_i = mk_flit(3'b000, 16'h0F0F);
        nd_i   = 1'b1;
        @(negedge clk);
        checks++; if (rd_o !== 1'b1) begin errors++; $display("FAIL conc_rd got %b exp 1", rd_o); end
        next_cycle();
        nd_i = 1'b0;
        @(negedge clk);
        checks++; if (ack_o !== 4'b0001) begin errors++; $display("FAIL conc_ack got %b exp 0001", ack_o); end
        checks++; if (rx_valid_o !== 4'b0001) begin errors++; $display("FAIL conc_valid got %b exp 0001", rx_valid_o); end
        next_cycle();
        req_i = 4'b0000;
        rx_ready_i = 4'b0001;
        next_cycle();
        rx_ready_i = 4'b0000;
    endtask

    // Random traffic against a model stated in terms of the rules:
    // one pending transfer at a time, rotating priority, a router flit queue,
    // a 2-cycle read gap and per-client delivery.
    task automatic test_random(input int ncyc);
        logic [BUS-1:0] rq [$];
        logic [BUS-1:0] fl [4];
        logic [3:0]     req;
        logic [BUS-1:0] held;
        logic [BUS-1:0] head;
        logic [3:0]     exp_ack, exp_valid;
        logic           exp_wr, exp_rd, exp_drop;
        int busy, cur, last, holding, rd_ok, drop_due;
        do_reset();
        req = 4'b0; busy = 0; cur = 0; last = 3;
        holding = 0; held = '0; rd_ok = 0; drop_due = -1;
        for (int k = 0; k < 4; k++) fl[k] = '0;
        for (int c = 0; c < ncyc; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (!req[k] && ($urandom % 3 == 0)) begin
                    req[k] = 1'b1;
                    fl[k]  = BUS'($urandom);
                end
                flit_i[k*BUS +: BUS] = fl[k];
            end
            req_i  = req;
            wait_i = ($urandom % 4 == 0);
            if ($urandom % 3 == 0) rq.push_back(mk_flit(3'($urandom), 16'($urandom)));
            nd_i   = (rq.size() > 0);
            head   = nd_i ? rq[0] : BUS'($urandom);
            dout_i = head;
            rx_ready_i = 4'($urandom);

            exp_wr    = (busy != 0) && !wait_i;
            exp_ack   = exp_wr ? (4'b0001 << cur) : 4'b0000;
            exp_rd    = nd_i && (holding == 0) && (c >= rd_ok);
            exp_valid = (holding != 0) ? (4'b0001 << held[17:16]) : 4'b0000;
            exp_drop  = (drop_due == c);

            @(negedge clk);
            checks++; if (wr_o !== exp_wr) begin errors++; $display("FAIL rnd_wr c%0d got %b exp %b", c, wr_o, exp_wr); end
            checks++; if (ack_o !== exp_ack) begin errors++; $display("FAIL rnd_ack c%0d got %b exp %b", c, ack_o, exp_ack); end
            if (busy != 0) begin
                checks++; if (din_o !== fl[cur]) begin errors++; $display("FAIL rnd_din c%0d got %h exp %h", c, din_o, fl[cur]); end
            end
            checks++; if (rd_o !== exp_rd) begin errors++; $display("FAIL rnd_rd c%0d got %b exp %b", c, rd_o, exp_rd); end
            checks++; if (rx_valid_o !== exp_valid) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, rx_valid_o, exp_valid); end
            if (holding != 0) begin
                checks++; if (rx_data_o !== held) begin errors++; $display("FAIL rnd_rx_data c%0d got %h exp %h", c, rx_data_o, held); end
            end
            checks++; if (drop_o !== exp_drop) begin errors++; $display("FAIL rnd_drop c%0d got %b exp %b", c, drop_o, exp_drop); end

            if (busy != 0) begin
                if (exp_wr) begin
                    req[cur] = 1'b0;
                    last = cur;
                    busy = 0;
                end
            end else if (req != 4'b0) begin
                for (int k = 1; k <= 4; k++) begin
                    if (req[(last + k) % 4]) begin
                        cur = (last + k) % 4;
                        break;
                    end
                end
                busy = 1;
            end

            if (exp_rd) begin
                void'(rq.pop_front());
                rd_ok = c + 3;
                if (head[18]) drop_due = c + 1;
                else begin
                    holding = 1;
                    held = head;
                end
            end else if ((holding != 0) && rx_ready_i[held[17:16]]) begin
                holding = 0;
            end
            next_cycle();
        end
        req_i = '0; nd_i = 1'b0; wait_i = 1'b0; rx_ready_i = '0;
        next_cycle();
    endtask

    initial begin
        rst_i = 1'b1; req_i = '0; flit_i = '0; wait_i = 1'b0;
        dout_i = '0; nd_i = 1'b0; rx_ready_i = '0;
        test_reset();
        test_round_robin();
        test_wait_hold();
        test_rx_deliver();
        test_rx_drop();
        test_reset_mid();
        test_concurrent();
        test_random(600);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
